// File: rtl/grs_reset_seq.sv
// Global reset sequencer: qualifies PLL lock, stretches the GRS_N pulse,
// then releases user reset after a gap. Any reset event (PLL loss,
// debounced board reset, software request) restarts the sequence from HOLD.
module grs_reset_seq #(
  parameter int unsigned LOCK_CYC     = 16,
  parameter int unsigned STRETCH_CYC  = 8,
  parameter int unsigned GAP_CYC      = 4,
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       ext_rst_n,
  input  logic       sw_rst_req,
  output logic       grs_n,
  output logic       sys_rst_n,
  output logic [1:0] state,
  output logic [1:0] rst_cause
);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    GAP     = 2'd2,
    RUN     = 2'd3
  } state_e;

  localparam logic [15:0] LOCK_TC    = 16'(LOCK_CYC - 1);
  localparam logic [15:0] STRETCH_TC = 16'(STRETCH_CYC - 1);
  localparam logic [15:0] GAP_TC     = 16'(GAP_CYC - 1);
  localparam logic [7:0]  DEB_TC     = 8'(DEBOUNCE_CYC - 1);

  localparam logic [1:0] CAUSE_PLL = 2'd1;
  localparam logic [1:0] CAUSE_EXT = 2'd2;
  localparam logic [1:0] CAUSE_SW  = 2'd3;

  logic [1:0]  sync_q;
  logic [7:0]  deb_cnt_q, deb_cnt_d;
  logic        ext_evt_q, ext_evt_d;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic        grs_q, grs_d;
  logic        sys_q, sys_d;
  logic        rst_evt;

  // Two-flop synchronizer for the asynchronous board reset (idles high).
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[0], ext_rst_n};
  end

  // Debounce: count consecutive synchronized samples that disagree with the
  // current filtered value; flip after DEBOUNCE_CYC of them.
  always_comb begin
    deb_cnt_d = '0;
    ext_evt_d = ext_evt_q;
    // sample disagrees when the line level equals the event flag
    // (low line while no event, or high line while event asserted)
    if (sync_q[1] == ext_evt_q) begin
      if (deb_cnt_q == DEB_TC) begin
        ext_evt_d = ~ext_evt_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 8'd1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q <= '0;
      ext_evt_q <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      ext_evt_q <= ext_evt_d;
    end
  end

  assign rst_evt = ~pll_lock | ext_evt_q | sw_rst_req;

  // Sequencer next state, phase counter, cause capture and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    if (rst_evt) begin
      state_d = HOLD;
      cnt_d   = '0;
      if (state_q != HOLD) begin
        if (!pll_lock)      cause_d = CAUSE_PLL;
        else if (ext_evt_q) cause_d = CAUSE_EXT;
        else                cause_d = CAUSE_SW;
      end
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == LOCK_TC) begin
            state_d = STRETCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        STRETCH: begin
          if (cnt_q == STRETCH_TC) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_TC) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      endcase
    end
    // outputs decoded from the next state so they are flops aligned with state
    grs_d = (state_d == GAP) || (state_d == RUN);
    sys_d = (state_d == RUN);
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      cause_q <= '0;
      grs_q   <= 1'b0;
      sys_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      grs_q   <= grs_d;
      sys_q   <= sys_d;
    end
  end

  assign grs_n     = grs_q;
  assign sys_rst_n = sys_q;
  assign state     = state_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_grs_reset_seq.sv
// Bench for grs_reset_seq: directed sequences plus randomized traffic, all
// checked every cycle against a phase/elapsed-time model of the sequencer.
module tb_grs_reset_seq;

  localparam int LOCK = 16;
  localparam int STR  = 8;
  localparam int GAPC = 4;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       rst, pll_lock, ext_rst_n, sw_rst_req;
  logic       grs_n, sys_rst_n;
  logic [1:0] state, rst_cause;

  grs_reset_seq #(
    .LOCK_CYC    (LOCK),
    .STRETCH_CYC (STR),
    .GAP_CYC     (GAPC),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .ext_rst_n (ext_rst_n),
    .sw_rst_req(sw_rst_req),
    .grs_n     (grs_n),
    .sys_rst_n (sys_rst_n),
    .state     (state),
    .rst_cause (rst_cause)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 HOLD, 1 STRETCH, 2 GAP, 3 RUN; elapsed = cycles spent in phase.
  int m_phase = 0, m_elapsed = 0, m_cause = 0;
  bit m_evt = 0;
  bit hist[$];   // ext samples in flight through the synchronizer
  bit win[$];    // last DEB synchronized samples
  int dur[3] = '{LOCK, STR, GAPC};

  always @(posedge clk) begin
    bit ev, s, lo, hi, nevt;
    if (rst) begin
      m_phase = 0; m_elapsed = 0; m_cause = 0; m_evt = 0;
      hist = {1'b1, 1'b1};
      win.delete();
      for (int i = 0; i < DEB; i++) win.push_back(1'b1);
    end else begin
      ev = !pll_lock || m_evt || sw_rst_req;
      hist.push_back(ext_rst_n);
      s = hist.pop_front();
      win.push_back(s);
      void'(win.pop_front());
      lo = 1; hi = 1;
      foreach (win[i]) begin
        if (win[i]) lo = 0;
        else        hi = 0;
      end
      nevt = lo ? 1'b1 : (hi ? 1'b0 : m_evt);
      if (ev) begin
        if (m_phase != 0) m_cause = !pll_lock ? 1 : (m_evt ? 2 : 3);
        m_phase = 0;
        m_elapsed = 0;
      end else if (m_phase != 3) begin
        m_elapsed++;
        if (m_elapsed == dur[m_phase]) begin
          m_phase++;
          m_elapsed = 0;
        end
      end
      m_evt = nevt;
    end
  end

  // Every-cycle comparison against the model, plus the output ordering invariant.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",     16'(state),     16'(m_phase));
      chk("grs_n",     16'(grs_n),     16'(m_phase >= 2));
      chk("sys_rst_n", 16'(sys_rst_n), 16'(m_phase == 3));
      chk("rst_cause", 16'(rst_cause), 16'(m_cause));
      chk("sys_implies_grs", 16'(sys_rst_n & ~grs_n), 16'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(int k);
    while (cyc < k) tick();
  endtask

  // Leaves the bench at cycle 0: first cycle whose closing edge sees rst low.
  task automatic do_reset();
    rst = 1; pll_lock = 1; ext_rst_n = 1; sw_rst_req = 0;
    tick();
    tick();
    rst = 0;
    cyc = 0;
  endtask

  // Hand-computed expectations, applied to both DUT and model.
  task automatic pin(string nm, int st, int g, int s);
    chk({nm, " state"}, 16'(state), 16'(st));
    chk({nm, " grs_n"}, 16'(grs_n), 16'(g));
    chk({nm, " sys_rst_n"}, 16'(sys_rst_n), 16'(s));
    chk({nm, " model"}, 16'(m_phase), 16'(st));
  endtask

  task automatic pin_cause(string nm, int c);
    chk({nm, " rst_cause"}, 16'(rst_cause), 16'(c));
    chk({nm, " model cause"}, 16'(m_cause), 16'(c));
  endtask

  // Clean power-up: HOLD 0-15, STRETCH 16-23, GAP 24-27, RUN from 28.
  task automatic seq_check(string nm);
    pin({nm, " c0"}, 0, 0, 0);
    run_to(15); pin({nm, " c15"}, 0, 0, 0);
    run_to(16); pin({nm, " c16"}, 1, 0, 0);
    run_to(23); pin({nm, " c23"}, 1, 0, 0);
    run_to(24); pin({nm, " c24"}, 2, 1, 0);
    run_to(27); pin({nm, " c27"}, 2, 1, 0);
    run_to(28); pin({nm, " c28"}, 3, 1, 1);
  endtask

  initial begin
    int ext_left;
    rst = 1; pll_lock = 1; ext_rst_n = 1; sw_rst_req = 0;
    tick();
    chk_en = 1;
    pin("reset", 0, 0, 0);
    pin_cause("reset", 0);

    // Power-up sequence.
    do_reset();
    seq_check("powerup");

    // One-cycle PLL glitch at lock count 10 restarts qualification;
    // grs_n rises 25 cycles after the glitch cycle.
    do_reset();
    run_to(10);
    pll_lock = 0;
    tick();
    pll_lock = 1;
    pin("glitch c11", 0, 0, 0);
    run_to(34); pin("glitch c34", 1, 0, 0);
    run_to(35); pin("glitch c35", 2, 1, 0);

    // Board reset: a 3-cycle low is filtered; a long low reaches HOLD
    // 6 edges after the first edge that samples it low.
    do_reset();
    run_to(30);
    ext_rst_n = 0;
    run_to(33);
    ext_rst_n = 1;
    run_to(45); pin("ext short", 3, 1, 1);
    ext_rst_n = 0;
    run_to(51); pin("ext long c51", 3, 1, 1);
    run_to(52); pin("ext long c52", 0, 0, 0);
    pin_cause("ext long", 2);
    run_to(54);
    ext_rst_n = 1;

    // Simultaneous software request and PLL loss in GAP: PLL loss wins.
    do_reset();
    run_to(25); pin("gap c25", 2, 1, 0);
    sw_rst_req = 1; pll_lock = 0;
    tick();
    sw_rst_req = 0; pll_lock = 1;
    pin("gap c26", 0, 0, 0);
    pin_cause("gap c26", 1);

    // rst during STRETCH clears everything, then the sequence repeats.
    begin
      int n = 0;
      while (m_phase != 1 && n < 100) begin
        tick();
        n++;
      end
      chk("reach stretch", 16'(m_phase), 16'd1);
    end
    rst = 1;
    tick();
    pin("rst in stretch", 0, 0, 0);
    pin_cause("rst in stretch", 0);
    rst = 0;
    cyc = 0;
    seq_check("rerun");

    // Randomized traffic, checked every cycle by the compare process.
    ext_left = 0;
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(599) == 0);
      pll_lock   = ($urandom_range(79) != 0);
      sw_rst_req = ($urandom_range(149) == 0);
      if (ext_left > 0) begin
        ext_rst_n = 0;
        ext_left--;
      end else begin
        ext_rst_n = 1;
        if ($urandom_range(99) == 0) ext_left = $urandom_range(9, 1);
      end
      tick();
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "timeout");
  end

endmodule
